// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one multi-cycle ALU between two
// requesters. Holds alu_start through the operation and returns the result
// to the winner, saturated on signed overflow.
// Optional: define ALU_ARB_TIMEOUT_EN to abort operations after TIMEOUT RUN
// cycles (result flagged with res_err).
module alu_share_arbiter #(
    parameter int DATA_W  = 16,
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    input  logic              alu_signov,
    output logic              res_valid,
    output logic              res_id,
    output logic [DATA_W-1:0] res_y,
    output logic              res_carry,
    output logic              res_ovf,
    output logic              res_err
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};

    state_t state_q, state_d;
    logic   last_q;     // requester served last; also owner of the op in flight
    logic   grant, win, finish, abort;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and arbitration decision
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: if (req0 || req1) begin
                grant   = 1'b1;
                // contention goes to whoever was not served last
                win     = (req0 && req1) ? ~last_q : req1;
                state_d = RUN;
            end
            RUN: if (alu_done) begin
                finish  = 1'b1;
                state_d = RESP;
            end
`ifdef ALU_ARB_TIMEOUT_EN
            // a done arriving on the final count still wins
            else if (cnt_q == TO_LAST) begin
                abort   = 1'b1;
                state_d = RESP;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Grant pulses, ALU drive and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;  // so requester 0 wins first contention
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_start <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_y     <= '0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            gnt0      <= grant & ~win;
            gnt1      <= grant & win;
            res_valid <= finish | abort;
            if (grant) begin
                last_q    <= win;
                alu_a     <= win ? a1 : a0;
                alu_b     <= win ? b1 : b0;
                alu_op    <= win ? op1 : op0;
                alu_start <= 1'b1;
            end
            if (finish) begin
                alu_start <= 1'b0;
                res_id    <= last_q;
                res_carry <= alu_carry;
                res_ovf   <= alu_signov;
                // clamp toward the sign of operand a on signed overflow
                if (alu_signov) res_y <= alu_a[DATA_W-1] ? SAT_NEG : SAT_POS;
                else            res_y <= alu_y;
            end
            if (abort) begin
                alu_start <= 1'b0;
                res_id    <= last_q;
                res_carry <= 1'b0;
                res_ovf   <= 1'b0;
                res_y     <= '0;
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    // RUN cycle counter, restarted by each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt_q <= '0;
        else if (grant)            cnt_q <= '0;
        else if (state_q == RUN)   cnt_q <= cnt_q + 1'b1;
    end

    // Error flag tracks the kind of the most recent result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_q <= 1'b0;
        else if (abort)  err_q <= 1'b1;
        else if (finish) err_q <= 1'b0;
    end

    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter. The ALU is modelled by
// the stimulus itself: alu_done is pulsed after a chosen number of RUN cycles.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [3:0]  op0 = '0, op1 = '0;
    logic        gnt0, gnt1, busy;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_y = '0;
    logic        alu_carry = 1'b0, alu_signov = 1'b0;
    logic        res_valid, res_id;
    logic [15:0] res_y;
    logic        res_carry, res_ovf, res_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(16), .OP_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_y(alu_y), .alu_carry(alu_carry), .alu_signov(alu_signov),
        .res_valid(res_valid), .res_id(res_id), .res_y(res_y),
        .res_carry(res_carry), .res_ovf(res_ovf), .res_err(res_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Called with the winner's request already presented in IDLE. Returns at
    // the negedge inside the RESP cycle. keep=0 drops the winner's req after grant.
    task automatic do_op(input logic id, input bit keep, input int run_n,
                         input logic [15:0] y, input logic cy, input logic ov,
                         input logic [15:0] ey);
        @(negedge clk);
        chk("gnt0", gnt0, !id);
        chk("gnt1", gnt1, id);
        chk("start_on", alu_start, 1);
        chk("busy_run", busy, 1);
        if (!keep) begin
            if (id) req1 = 1'b0; else req0 = 1'b0;
        end
        for (int i = 1; i < run_n; i++) begin
            @(negedge clk);
            chk("start_hold", alu_start, 1);
            chk("gnt_pulse", gnt0 | gnt1, 0);
        end
        alu_done = 1'b1; alu_y = y; alu_carry = cy; alu_signov = ov;
        @(negedge clk);
        alu_done = 1'b0; alu_y = 16'hdead; alu_carry = 1'b0; alu_signov = 1'b0;
        chk("res_valid", res_valid, 1);
        chk("res_id", res_id, id);
        chk("res_y", res_y, ey);
        chk("res_carry", res_carry, cy);
        chk("res_ovf", res_ovf, ov);
        chk("res_err", res_err, 0);
        chk("start_off", alu_start, 0);
    endtask

    // One cycle after RESP: back in IDLE, result held but not valid
    task automatic idle_after(input logic [15:0] ey);
        @(negedge clk);
        chk("rv_drop", res_valid, 0);
        chk("res_hold", res_y, ey);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_y", res_y, 0);

        // basic add: ALU answers after 2 RUN cycles
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 16'h0003; b0 = 16'h0004; op0 = 4'h0;
        @(negedge clk);
        chk("gnt0_basic", gnt0, 1);
        chk("alu_a", alu_a, 16'h0003);
        chk("alu_b", alu_b, 16'h0004);
        chk("alu_op", alu_op, 0);
        req0 = 1'b0;
        @(negedge clk);
        chk("start_2nd", alu_start, 1);
        chk("gnt0_pulse", gnt0, 0);
        alu_done = 1'b1; alu_y = 16'h0007;
        @(negedge clk);
        alu_done = 1'b0;
        chk("rv_basic", res_valid, 1);
        chk("rid_basic", res_id, 0);
        chk("ry_basic", res_y, 16'h0007);
        chk("start_lo", alu_start, 0);
        idle_after(16'h0007);
        chk("idle_busy", busy, 0);

        // both held from reset: alternate 0,1,0,1
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'h1111; a1 = 16'h2222; b0 = 16'h0001; b1 = 16'h0002;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 1, 1, 16'h1112, 0, 0, 16'h1112); idle_after(16'h1112);
        do_op(1, 1, 3, 16'h2224, 1, 0, 16'h2224); idle_after(16'h2224);
        do_op(0, 1, 2, 16'h0a0a, 0, 0, 16'h0a0a); idle_after(16'h0a0a);
        do_op(1, 0, 1, 16'h0b0b, 0, 0, 16'h0b0b);
        req0 = 1'b0;
        idle_after(16'h0b0b);

        // saturation: negative a -> 0x8000, positive a -> 0x7FFF
        req0 = 1'b1; a0 = 16'h8000; b0 = 16'h8000;
        do_op(0, 0, 1, 16'h0000, 1, 1, 16'h8000); idle_after(16'h8000);
        req0 = 1'b1; a0 = 16'h7FFF; b0 = 16'h0001;
        do_op(0, 0, 2, 16'h8000, 0, 1, 16'h7FFF); idle_after(16'h7FFF);

        // alu_done in IDLE with no requests is ignored
        alu_done = 1'b1; alu_y = 16'h5555;
        @(negedge clk);
        alu_done = 1'b0;
        chk("ign_busy", busy, 0);
        chk("ign_rv", res_valid, 0);
        @(negedge clk);
        chk("ign_rv2", res_valid, 0);
        chk("ign_y", res_y, 16'h7FFF);

        // asynchronous reset mid-RUN
        req1 = 1'b1; a1 = 16'h0055; b1 = 16'h0005; op1 = 4'h3;
        @(negedge clk);
        chk("gnt1_pre", gnt1, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_start", alu_start, 0);
        chk("ar_busy", busy, 0);
        chk("ar_a", alu_a, 0);
        chk("ar_op", alu_op, 0);
        chk("ar_y", res_y, 0);
        @(negedge clk);
        chk("ar_rv", res_valid, 0);
        rst_n = 1'b1;
        do_op(1, 0, 1, 16'h0050, 0, 0, 16'h0050); idle_after(16'h0050);

        // ALU never answers
        req0 = 1'b1; a0 = 16'h0001;
`ifdef ALU_ARB_TIMEOUT_EN
        @(negedge clk);
        chk("to_gnt", gnt0, 1);
        req0 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("to_start", alu_start, 1);
        end
        @(negedge clk);
        chk("to_rv", res_valid, 1);
        chk("to_err", res_err, 1);
        chk("to_y", res_y, 0);
        chk("to_ovf", res_ovf, 0);
        chk("to_start_off", alu_start, 0);
        @(negedge clk);
        chk("to_idle", busy, 0);
`else
        @(negedge clk);
        chk("nt_gnt", gnt0, 1);
        req0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("nt_busy", busy, 1);
        chk("nt_start", alu_start, 1);
        chk("nt_rv", res_valid, 0);
        alu_done = 1'b1; alu_y = 16'h0042;
        @(negedge clk);
        alu_done = 1'b0;
        chk("nt_rv_end", res_valid, 1);
        chk("nt_y", res_y, 16'h0042);
        chk("nt_err", res_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // gnt0 and gnt1 never high together; res_valid never with alu_start
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 && gnt1) chk("dbl_gnt", {gnt0, gnt1}, 2'b00);
            if (res_valid && alu_start) chk("rv_start", alu_start, 0);
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single multi-cycle ALU (start/done handshake, 16-bit operands, 4-bit opcode, carry and signed-overflow outputs) between two requesters, e.g. the instruction control unit and a secondary sequencer. It arbitrates round-robin and drives the ALU operand/opcode/start lines. It holds start until the ALU reports done, then returns the result to the winning requester with saturation applied on signed overflow. It sits between the requesters and the ALU.

## Interface
- DATA_W, 16, operand/result width
- OP_W, 4, ALU opcode width
- TIMEOUT, 64, maximum RUN cycles before abort (used only with the timeout feature)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from requester 0 / 1; held until its grant
- a0, b0 / a1, b1  in  DATA_W  operands of requester 0 / 1
- op0 / op1  in  OP_W  opcode of requester 0 / 1
- gnt0 / gnt1  out  1  one-cycle pulse: operands sampled, request accepted
- busy  out  1  high whenever state is not IDLE
- alu_a, alu_b  out  DATA_W  registered operands to ALU
- alu_op  out  OP_W  registered opcode to ALU
- alu_start  out  1  held high for the whole ALU operation
- alu_done  in  1  ALU completion strobe
- alu_y  in  DATA_W  ALU result
- alu_carry, alu_signov  in  1  ALU carry / signed overflow
- res_valid  out  1  one-cycle result strobe
- res_id  out  1  requester owning the result (0/1)
- res_y  out  DATA_W  result, saturated on overflow
- res_carry, res_ovf  out  1  captured carry / overflow flags
- res_err  out  1  operation aborted by timeout

## Operation
- Reset: state IDLE, every output 0, round-robin pointer favours requester 0.
- FSM IDLE -> RUN -> RESP -> IDLE.
- IDLE arbitration:
  - One requester asserting req wins.
  - If both assert, the requester not served last wins; the pointer updates on every grant.
  - On the grant edge the winner's a/b/op are registered into alu_a/alu_b/alu_op, gntN pulses, alu_start goes high and the state moves to RUN.
- RUN: alu_start and the operands stay stable. On the first edge with alu_done=1:
  - Capture result and flags.
  - alu_start goes low, state goes to RESP.
- RESP: res_valid=1 for exactly one cycle with res_id, res_carry=alu_carry and res_ovf=alu_signov.
  - res_y = alu_y when signov=0.
  - When signov=1: res_y = 16'h8000 if alu_a[15]=1, else 16'h7FFF.
  - Then IDLE.
- Outside RESP, res_* hold their last values; only res_valid qualifies them.
- Ignored inputs: alu_done is ignored in IDLE and RESP. req is not sampled outside IDLE, so a loser simply keeps requesting.
- Withdrawal: dropping req before its grant withdraws the request, with no side effects.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No res_valid is produced for the lost operation.

## Timing
- Request sampled at IDLE edge k: gnt and alu_start are high in cycle k+1.
- alu_done sampled at edge m: res_valid is high in cycle m+1, state is IDLE after edge m+1, and the earliest next grant is sampled at edge m+2.
- Minimum throughput (alu_done in the first RUN cycle): one operation per 3 cycles.
- gnt0 and gnt1 are never high together. res_valid never coincides with alu_start.

## Configuration
- ALU_ARB_TIMEOUT_EN defined:
  - A counter (width ceil(log2(TIMEOUT+1))) clears on grant and increments each RUN cycle.
  - If it reaches TIMEOUT without alu_done: alu_start drops, state goes to RESP, res_err=1, res_y=0 and flags 0.
  - alu_done sampled in the same cycle the count reaches TIMEOUT wins (normal completion, res_err=0).
- Undefined: no counter. RUN waits indefinitely and res_err is tied 0. The port list is identical in both cases.

## Test plan
- Reset then req0, a0=0x0003, b0=0x0004, op0=0, ALU returns y=0x0007 after 2 RUN cycles -> gnt0 one cycle, alu_start high 2 cycles, res_valid with res_id=0, res_y=0x0007.
- req0 and req1 both held from reset -> grants alternate 0,1,0,1 across four operations, with no double grant.
- ALU returns signov=1 with alu_a=0x8000 -> res_y=0x8000, res_ovf=1. With alu_a=0x7FFF and signov=1 -> res_y=0x7FFF.
- rst_n pulled low during RUN -> all outputs 0 asynchronously. After release no res_valid appears, and req1 pending is granted first only if req0 is absent.
- With ALU_ARB_TIMEOUT_EN, TIMEOUT=4, alu_done never asserted -> alu_start high 4 cycles, then res_valid with res_err=1, res_y=0. Without the macro -> busy stays high indefinitely.
- alu_done pulsed while IDLE with no requests -> no state change, res_valid stays 0.
